// File: rtl/rom_register_loader_if.sv
// Control, ROM-port and single-word write signals of the ROM register loader.
interface rom_register_loader_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       rom_addr;
  logic [WIDTH-1:0] rom_data;
  logic             wr_en;
  logic [3:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             wr_drop;

  // master is the surrounding system (controller plus synchronous ROM)
  modport master (
    output start, rom_data, wr_en, wr_addr, wr_data,
    input  rom_addr, busy, done, wr_drop
  );

  modport slave (
    input  start, rom_data, wr_en, wr_addr, wr_data,
    output rom_addr, busy, done, wr_drop
  );
endinterface

// File: rtl/rom_register_loader.sv
// Bank of 16 registers feeding the 16:1 word mux; copies ROM words 0..15 on command
// and accepts single-word patches while idle.
module rom_register_loader #(
  parameter int unsigned WIDTH     = 32,
  parameter bit          AUTO_LOAD = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  rom_register_loader_if.slave bus,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCopy = 2'd1;
  localparam logic [1:0] StFin  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [3:0]       rd_ptr_q, rd_ptr_d;
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             drop_q, drop_d;
  logic             auto_q;
  logic             trig;
  logic             load_en;
  logic             ext_en;
  logic [WIDTH-1:0] regs_q [16];

  // auto_q is set only by reset, so it fires on the first edge after rst_n rises
  assign trig = bus.start | auto_q;

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    vld_d    = vld_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    drop_d   = bus.wr_en & (state_q != StIdle);
    load_en  = 1'b0;
    ext_en   = 1'b0;
    case (state_q)
      StIdle: begin
        ext_en = bus.wr_en;
        if (trig) begin
          state_d  = StCopy;
          rd_ptr_d = 4'd0;
          wr_ptr_d = 4'd0;
          vld_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      StCopy: begin
        if (rd_ptr_q != 4'd15) rd_ptr_d = rd_ptr_q + 4'd1;
        // rom_data becomes meaningful one edge after the first address is presented
        vld_d = 1'b1;
        if (vld_q) begin
          load_en = 1'b1;
          if (wr_ptr_q == 4'd15) begin
            state_d = StFin;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            wr_ptr_d = wr_ptr_q + 4'd1;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rd_ptr_q <= 4'd0;
      wr_ptr_q <= 4'd0;
      vld_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      auto_q   <= AUTO_LOAD;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      vld_q    <= vld_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      drop_q   <= drop_d;
      auto_q   <= 1'b0;
    end
  end

  // Loader and external port never write in the same cycle: one is COPY-only, the other IDLE-only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else if (load_en) begin
      regs_q[wr_ptr_q] <= bus.rom_data;
    end else if (ext_en) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.rom_addr = rd_ptr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wr_drop  = drop_q;

  assign q0  = regs_q[0];
  assign q1  = regs_q[1];
  assign q2  = regs_q[2];
  assign q3  = regs_q[3];
  assign q4  = regs_q[4];
  assign q5  = regs_q[5];
  assign q6  = regs_q[6];
  assign q7  = regs_q[7];
  assign q8  = regs_q[8];
  assign q9  = regs_q[9];
  assign q10 = regs_q[10];
  assign q11 = regs_q[11];
  assign q12 = regs_q[12];
  assign q13 = regs_q[13];
  assign q14 = regs_q[14];
  assign q15 = regs_q[15];

endmodule
